riscv_fetch_queue: RTL and testbench
====================================

RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the instruction queue entries; power of two, >= 2.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-004 The block SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port redirect_i  in  1  taken branch/jump; flush and restart fetch.
REQ-007 The block SHALL have port redirect_pc_i  in  XLEN  new fetch address; bits [1:0] are forced to 0.
REQ-008 The block SHALL have port imem_req_o  out  1  fetch request valid.
REQ-009 The block SHALL have port imem_addr_o  out  XLEN  fetch address, word aligned.
REQ-010 The block SHALL have port imem_gnt_i  in  1  request accepted this cycle.
REQ-011 The block SHALL have port imem_rvalid_i  in  1  in-order response valid.
REQ-012 The block SHALL have port imem_rdata_i  in  32  response instruction word.
REQ-013 The block SHALL have port inst_valid_o  out  1  queue head valid.
REQ-014 The block SHALL have port inst_o  out  32  head instruction.
REQ-015 The block SHALL have port inst_pc_o  out  XLEN  head PC.
REQ-016 The block SHALL have port inst_pc4_o  out  XLEN  head PC + 4, mod 2^XLEN.
REQ-017 The block SHALL have port inst_ready_i  in  1  decode consumes head when inst_valid_o.
REQ-018 The block SHALL have port count_o  out  clog2(DEPTH+1)  queue occupancy.
REQ-019 The block SHALL have port err_o  out  1  sticky spurious-response flag.

Function
REQ-020 The block SHALL hold fetch PC register fpc; imem_addr_o = fpc combinationally.
REQ-021 The block SHALL assert imem_req_o iff not rst, not redirect_i, and count + outstanding < DEPTH (credit rule), so the queue never overflows.
REQ-022 The block SHALL, on imem_req_o & imem_gnt_i, set fpc <= fpc + 4 (wraps mod 2^XLEN), increment outstanding, and push the issued PC into an in-order PC tag FIFO.
REQ-023 The block SHALL, on imem_rvalid_i with outstanding > 0 and discard == 0, write {imem_rdata_i, tag PC} into the queue tail; queue entry is visible at inst_valid_o next cycle (1-cycle response-to-head latency).
REQ-024 The block SHALL, on imem_rvalid_i with discard > 0, drop the response and decrement discard and outstanding.
REQ-025 The block SHALL, on imem_rvalid_i with outstanding == 0, ignore the data and set err_o, which holds until reset.
REQ-026 The block SHALL pop the head on inst_valid_o & inst_ready_i; simultaneous push and pop leave count unchanged.
REQ-027 The block SHALL present inst_o/inst_pc_o/inst_pc4_o stable while inst_valid_o & !inst_ready_i.
REQ-028 The block SHALL, on redirect_i, next cycle: set fpc = {redirect_pc_i[XLEN-1:2],2'b00}, count = 0, inst_valid_o = 0, and set discard = outstanding (including any grant and excluding any response in the redirect cycle).
REQ-029 The block SHALL treat redirect_i as higher priority than same-cycle rvalid, gnt and pop: that cycle's rvalid is dropped, and a grant cannot occur because req is low.
REQ-030 The block SHALL keep queue and tag FIFO pointers wrapping modulo DEPTH with an extra wrap bit for full/empty.

Reset
REQ-031 The block SHALL, with rst high at a clock edge, set fpc = RESET_PC, count = 0, outstanding = 0, discard = 0, err_o = 0, inst_valid_o = 0; imem_req_o SHALL be 0 while rst is high.
REQ-032 The block SHALL, on reset mid-operation, abandon in-flight responses; responses after reset with outstanding == 0 set err_o (the environment must quiesce imem).

Verification
REQ-033 The bench SHALL cover: reset with gnt=1, rvalid 1 cycle later, and ready=1 -> addresses 0x0,0x4,0x8 issued on consecutive cycles; inst_pc_o sequence 0x0,0x4,0x8; inst_pc4_o = pc+4.
REQ-034 The bench SHALL cover: inst_ready_i=0 with DEPTH=4 -> exactly 4 grants, then imem_req_o=0, count_o=4, head held at PC 0x0.
REQ-035 The bench SHALL cover: redirect_i with redirect_pc_i=0x103 while 2 requests are outstanding -> next address 0x100, the 2 late responses are dropped, and the first valid head has PC 0x100.
REQ-036 The bench SHALL cover: redirect_i coincident with rvalid and pop -> count_o=0 next cycle, with no stale instruction at the head.
REQ-037 The bench SHALL cover: rvalid with outstanding=0 -> err_o=1 sticky, and count_o is unchanged.
REQ-038 The bench SHALL cover: RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000; inst_pc4_o of the first instruction = 0x0.

Source files
------------

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch unit: credit-limited request issue, in-order PC tag FIFO and a
// small instruction queue, with redirect flush that discards late memory responses.
module riscv_fetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         redirect_i,
   input  logic [XLEN-1:0]              redirect_pc_i,
   output logic                         imem_req_o,
   output logic [XLEN-1:0]              imem_addr_o,
   input  logic                         imem_gnt_i,
   input  logic                         imem_rvalid_i,
   input  logic [31:0]                  imem_rdata_i,
   output logic                         inst_valid_o,
   output logic [31:0]                  inst_o,
   output logic [XLEN-1:0]              inst_pc_o,
   output logic [XLEN-1:0]              inst_pc4_o,
   input  logic                         inst_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         err_o
);

   localparam int unsigned     AW      = $clog2(DEPTH);
   localparam int unsigned     PW      = AW + 1;
   localparam logic [PW:0]     DEPTH_W = DEPTH[PW:0];
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [PW-1:0]   q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
   logic [PW-1:0]   t_wptr_q, t_wptr_d, t_rptr_q, t_rptr_d;
   logic [PW-1:0]   discard_q, discard_d;
   logic            err_q, err_d;

   logic [31:0]     inst_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [XLEN-1:0] tag_mem  [DEPTH];

   logic [PW-1:0]   count;
   logic [PW-1:0]   outstanding;
   logic [PW:0]     inflight;
   logic            grant;
   logic            rsp_hit;
   logic            rsp_push;
   logic            rsp_drop;
   logic            pop;
   logic [XLEN-1:0] tag_head;
   logic            unused_pc_lsbs;

   assign unused_pc_lsbs = ^redirect_pc_i[1:0];

   assign count       = q_wptr_q - q_rptr_q;
   assign outstanding = t_wptr_q - t_rptr_q;
   assign inflight    = {1'b0, count} + {1'b0, outstanding};

   // Every granted request reserves a queue slot until its response is consumed.
   assign imem_req_o  = !rst && !redirect_i && (inflight < DEPTH_W);
   assign imem_addr_o = fpc_q;

   assign grant    = imem_req_o && imem_gnt_i;
   assign rsp_hit  = imem_rvalid_i && (outstanding != '0);
   assign rsp_push = rsp_hit && (discard_q == '0) && !redirect_i;
   assign rsp_drop = rsp_hit && (discard_q != '0);
   assign pop      = inst_valid_o && inst_ready_i && !redirect_i;
   assign tag_head = tag_mem[t_rptr_q[AW-1:0]];

   always_comb begin
      fpc_d     = fpc_q;
      q_wptr_d  = q_wptr_q;
      q_rptr_d  = q_rptr_q;
      t_wptr_d  = t_wptr_q;
      t_rptr_d  = t_rptr_q;
      discard_d = discard_q;
      err_d     = err_q;

      if (imem_rvalid_i && (outstanding == '0))
         err_d = 1'b1;
      if (grant) begin
         fpc_d    = fpc_q + PC_STEP;
         t_wptr_d = t_wptr_q + PW'(1);
      end
      if (rsp_hit)
         t_rptr_d = t_rptr_q + PW'(1);

      // Responses still in flight at a redirect belong to the old path.
      if (redirect_i) begin
         fpc_d     = {redirect_pc_i[XLEN-1:2], 2'b00};
         q_rptr_d  = q_wptr_q;
         discard_d = outstanding - PW'(rsp_hit);
      end else begin
         if (rsp_push)
            q_wptr_d = q_wptr_q + PW'(1);
         if (pop)
            q_rptr_d = q_rptr_q + PW'(1);
         if (rsp_drop)
            discard_d = discard_q - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q     <= RESET_PC;
         q_wptr_q  <= '0;
         q_rptr_q  <= '0;
         t_wptr_q  <= '0;
         t_rptr_q  <= '0;
         discard_q <= '0;
         err_q     <= 1'b0;
      end else begin
         fpc_q     <= fpc_d;
         q_wptr_q  <= q_wptr_d;
         q_rptr_q  <= q_rptr_d;
         t_wptr_q  <= t_wptr_d;
         t_rptr_q  <= t_rptr_d;
         discard_q <= discard_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && grant)
         tag_mem[t_wptr_q[AW-1:0]] <= fpc_q;
      if (!rst && rsp_push) begin
         inst_mem[q_wptr_q[AW-1:0]] <= imem_rdata_i;
         pc_mem[q_wptr_q[AW-1:0]]   <= tag_head;
      end
   end

   assign inst_valid_o = (count != '0);
   assign inst_o       = inst_mem[q_rptr_q[AW-1:0]];
   assign inst_pc_o    = pc_mem[q_rptr_q[AW-1:0]];
   assign inst_pc4_o   = inst_pc_o + PC_STEP;
   assign count_o      = count;
   assign err_o        = err_q;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed scenarios, a behavioural instruction memory,
// and a scoreboard monitor that checks every instruction consumed by decode.
`timescale 1ns/1ps
module tb_riscv_fetch_queue;

   localparam logic [31:0] MAGIC = 32'hA5A5_0F0F;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;
   logic        ready;
   logic [2:0]  count;
   logic        err;

   logic        rst_b;
   logic        b_gnt;
   logic        b_rvalid;
   logic [31:0] b_rdata;
   logic        b_req;
   logic [31:0] b_addr;
   logic        b_valid;
   logic [31:0] b_inst;
   logic [31:0] b_pc;
   logic [31:0] b_pc4;
   logic [2:0]  b_count;
   logic        b_err;

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          gnt_budget;
   logic        rsp_en;
   logic        stray;
   exp_t        exp_q[$];
   logic [31:0] pend[$];
   logic [31:0] log_addr[$];
   int          log_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   riscv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc), .inst_pc4_o(inst_pc4),
      .inst_ready_i(ready), .count_o(count), .err_o(err)
   );

   riscv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_b (
      .clk(clk), .rst(rst_b), .redirect_i(1'b0), .redirect_pc_i(32'h0),
      .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(b_gnt),
      .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
      .inst_valid_o(b_valid), .inst_o(b_inst), .inst_pc_o(b_pc), .inst_pc4_o(b_pc4),
      .inst_ready_i(1'b1), .count_o(b_count), .err_o(b_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end else begin
         $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.inst = pc ^ MAGIC;
      exp_q.push_back(e);
   endtask

   // Memory model: grants while budget remains, answers in order one cycle after grant.
   initial begin
      logic [31:0] a;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            pend.delete();
            rvalid = 1'b0;
         end else if (stray) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
         end else if (rsp_en && pend.size() > 0) begin
            a      = pend.pop_front();
            rvalid = 1'b1;
            rdata  = a ^ MAGIC;
         end else begin
            rvalid = 1'b0;
         end
         gnt = (gnt_budget > 0);
         #1;
         if (req && gnt) begin
            pend.push_back(addr);
            log_addr.push_back(addr);
            log_cyc.push_back(cyc);
            gnt_budget--;
         end
      end
   end

   // Scoreboard monitor: every instruction taken by decode must match the next expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && inst_valid && ready && !redirect) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_head: got pc 0x%0h inst 0x%0h, expected no instruction (cycle %0d)",
                        inst_pc, inst, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("head_pc", inst_pc, e.pc);
               chk("head_inst", inst, e.inst);
               chk("head_pc4", inst_pc4, e.pc + 32'd4);
            end
         end
      end
   end

   task automatic do_reset(input int budget, input logic rdy, input logic rsp);
      @(negedge clk);
      rst = 1'b1; redirect = 1'b0; stray = 1'b0;
      ready = rdy; rsp_en = rsp; gnt_budget = budget;
      exp_q.delete(); log_addr.delete(); log_cyc.delete();
      @(negedge clk);
      #3;
      chk("rst_req", req, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", addr, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         #4;
         if (exp_q.size() == 0 && !inst_valid) break;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      ready = 1'b0; gnt_budget = 0; rsp_en = 1'b1; stray = 1'b0;
      rst_b = 1'b1; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
      repeat (2) @(negedge clk);

      // Streaming fetch with immediate decode.
      do_reset(3, 1'b1, 1'b1);
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      drain("t1", 30);
      chk("t1_grants", log_addr.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < log_addr.size()) begin
            chk("t1_addr", log_addr[i], 32'(i * 4));
            chk("t1_gap", log_cyc[i] - log_cyc[0], i);
         end
      end

      // Decode stalled: queue fills, requests stop at the credit limit.
      do_reset(6, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
      repeat (8) @(negedge clk);
      #3;
      chk("t2_grants", log_addr.size(), 4);
      chk("t2_req", req, 0);
      chk("t2_count", count, 4);
      chk("t2_valid", inst_valid, 1);
      chk("t2_head_pc", inst_pc, 32'h0);
      @(negedge clk);
      #3;
      chk("t2_hold_pc", inst_pc, 32'h0);
      chk("t2_hold_inst", inst, 32'h0 ^ MAGIC);
      @(negedge clk);
      ready = 1'b1;
      drain("t2", 30);
      chk("t2_total_grants", log_addr.size(), 6);

      // Redirect with two responses outstanding.
      do_reset(2, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      #3;
      chk("t3_issued", log_addr.size(), 2);
      @(negedge clk);
      redirect = 1'b0; rsp_en = 1'b1; gnt_budget = 2;
      push_exp(32'h100); push_exp(32'h104);
      #3;
      chk("t3_next_addr", addr, 32'h100);
      chk("t3_count", count, 0);
      drain("t3", 30);
      chk("t3_grants", log_addr.size(), 4);

      // Redirect in the same cycle as a response and a pop.
      do_reset(2, 1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      push_exp(32'h200);
      #3;
      chk("t4_head_valid", inst_valid, 1);
      chk("t4_count_before", count, 1);
      @(negedge clk);
      redirect = 1'b0; gnt_budget = 1;
      #3;
      chk("t4_count_after", count, 0);
      chk("t4_valid_after", inst_valid, 0);
      chk("t4_addr", addr, 32'h200);
      drain("t4", 30);

      // Spurious response with nothing outstanding.
      do_reset(2, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      #3;
      chk("t5_count_pre", count, 2);
      chk("t5_err_pre", err, 0);
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      #3;
      chk("t5_err", err, 1);
      chk("t5_count", count, 2);
      repeat (3) @(negedge clk);
      #3;
      chk("t5_err_sticky", err, 1);
      push_exp(32'h0); push_exp(32'h4);
      @(negedge clk);
      ready = 1'b1;
      drain("t5", 30);
      chk("t5_err_after_drain", err, 1);
      do_reset(0, 1'b0, 1'b1);

      // PC wrap-around from a reset vector at the top of the address space.
      @(negedge clk);
      #3;
      chk("b_rst_addr", b_addr, 32'hFFFF_FFFC);
      chk("b_rst_req", b_req, 0);
      @(negedge clk);
      rst_b = 1'b0; b_gnt = 1'b1;
      #3;
      chk("b_req", b_req, 1);
      chk("b_first_addr", b_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      #3;
      chk("b_second_addr", b_addr, 32'h0000_0000);
      @(negedge clk);
      b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'h0000_0013;
      @(negedge clk);
      b_rvalid = 1'b0;
      #3;
      chk("b_valid", b_valid, 1);
      chk("b_pc", b_pc, 32'hFFFF_FFFC);
      chk("b_pc4", b_pc4, 32'h0000_0000);
      chk("b_inst", b_inst, 32'h0000_0013);
      chk("b_err", b_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
